seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed driver for a NUM_DIGITS common-anode 7-segment display.
//   Latches a packed BCD/hex word and scans the digits round-robin, one digit slot at a time.
//   Decodes each nibble to active-low segments and inserts a blanking gap between digits to suppress ghosting.
//   Sits between the datapath (counter/score registers) and the board's segment and digit pins.
// PARAMETERS
//   NUM_DIGITS     4      number of digits scanned (>=1)
//   SCAN_DIV       50000  clk cycles per digit slot (>=2)
//   BLANK_CYC      500    leading cycles of each slot with all digits off (0 <= BLANK_CYC < SCAN_DIV)
//   DIG_ACTIVE_LOW 1      1: oDIG enable is 0; 0: oDIG enable is 1
// PORTS
//   clk     in   1             system clock
//   rst     in   1             asynchronous reset, active-low
//   iDATA   in   4*NUM_DIGITS  packed nibbles; digit k = iDATA[4k+3:4k]; digit 0 is rightmost
//   iDP     in   NUM_DIGITS    decimal point per digit, 1 = lit
//   iLOAD   in   1             1-cycle strobe: capture iDATA/iDP into the shadow registers
//   oSEG    out  8             {a,b,c,d,e,f,g,dp}, active-low, registered
//   oDIG    out  NUM_DIGITS    one-hot digit enable (polarity per DIG_ACTIVE_LOW), registered
// BEHAVIOUR
// - Reset (rst=0, async): shadow data/dp=0; slot counter=0; digit index=0; state=BLANK;
//   oSEG=8'hFF; oDIG all inactive. Reset mid-scan aborts the slot immediately.
// - iLOAD=1 at edge N: shadow updated at N. Held otherwise; iDATA is ignored without iLOAD.
// - Slot counter cnt counts 0..SCAN_DIV-1, then wraps to 0 and advances the index
//   (NUM_DIGITS-1 -> 0 wrap).
// - At cnt==0 the current digit's nibble/dp are sampled from the shadow into a slot register;
//   a load mid-slot never changes the digit on display (no tearing).
// - FSM:
//   - BLANK, cnt < BLANK_CYC: oDIG all inactive, oSEG=8'hFF.
//   - SHOW, cnt >= BLANK_CYC: oDIG enables only the current index; oSEG = decode.
//   - SHOW -> BLANK at the slot wrap. With BLANK_CYC=0, BLANK is skipped.
// - Outputs are registered: one cycle after the state/cnt they reflect. Scan period = NUM_DIGITS*SCAN_DIV.
// - Decode, bits [7:1]:
//     0=0000001  1=1001111  2=0010010  3=0000110  4=1001100  5=0100100  6=0100000  7=0001111
//     8=0000000  9=0000100  A=0001000  b=1100000  C=0110001  d=1000010  E=0110000  F=0111000
// - oSEG[0] = ~dp of the slot.
// - Counter width = $clog2(SCAN_DIV); index width = max(1,$clog2(NUM_DIGITS)).
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN
//   - Defined: in SHOW, a digit k>0 whose nibble is 0 and whose higher digits are all 0
//     in the shadow drives oSEG[7:1]=7'h7F (blank); dp is still honoured.
//     Digit 0 is always shown, so all-zero data displays a single "0".
//   - Undefined: every digit is decoded as-is, leading zeros shown.
// TESTING (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, DIG_ACTIVE_LOW=1)
//   1. Hold rst=0 -> oSEG=8'hFF, oDIG=4'b1111. Release; no load.
//      -> digit 0 SHOW shows oSEG=8'h03 with oDIG=4'b1110 on cycles 3..8 after release.
//   2. iLOAD with iDATA=16'h1234, iDP=0 -> per slot: 2 cycles oDIG=1111/oSEG=FF, then 6 cycles.
//      oSEG/oDIG pairs: 8'h99/1110, 8'h0D/1101, 8'h25/1011, 8'h9F/0111; wraps to digit 0 after cycle 32.
//   3. iDATA=16'hABCD, iDP=4'b0100 -> D=8'h85, C=8'h63, B=8'hC0 (dp lit), A=8'h11.
//   4. iLOAD 16'h5555 -> 16'h6666 at cnt==4 of digit 1 slot -> digit 1 shows 8'h49 to slot end,
//      digit 2 shows 8'h41.
//   5. rst pulsed low at cnt==5 of digit 2 -> outputs FF/1111 within the same cycle;
//      scan restarts at digit 0, shadow=0.
//   6. LEADING_ZERO_BLANK_EN, iDATA=16'h0070 -> digits 3,2 oSEG=8'hFF, digit 1=8'h1F, digit 0=8'h03;
//      iDATA=0 -> only digit 0 lit (8'h03).

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Round-robin scanner for a common-anode 7-segment display: shadow latch, per-slot blanking gap, hex decode.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] iDATA,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic                    iLOAD,
  output logic [7:0]              oSEG,
  output logic [NUM_DIGITS-1:0]   oDIG
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZ_EN = 1'b1;
`else
  localparam logic LZ_EN = 1'b0;
`endif

  typedef enum logic [0:0] {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      4'hF:    seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [4*NUM_DIGITS-1:0] shadow_data_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;
  logic [CW-1:0]           cnt_r, cnt_nxt_s;
  logic [IW-1:0]           idx_r, idx_nxt_s;
  state_t                  state_r, state_nxt_s;
  logic [3:0]              slot_nib_r, cur_nib_s;
  logic                    slot_dp_r, cur_dp_s;
  logic                    slot_blank_r, cur_blank_s, hi_nz_s;
  logic [NUM_DIGITS-1:0]   dig_on_s, hi_mask_s, dig_nxt_s;
  logic [6:0]              seg_bits_s;
  logic [7:0]              seg_nxt_s;

  // Shadow registers: only an iLOAD strobe changes the word being displayed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_data_r <= {4*NUM_DIGITS{1'b0}};
      shadow_dp_r   <= {NUM_DIGITS{1'b0}};
    end else if (iLOAD) begin
      shadow_data_r <= iDATA;
      shadow_dp_r   <= iDP;
    end
  end

  // Slot counter and digit index advance.
  always_comb begin
    cnt_nxt_s = cnt_r + CW'(1);
    idx_nxt_s = idx_r;
    if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = {CW{1'b0}};
      if (idx_r == IDX_MAX) begin
        idx_nxt_s = {IW{1'b0}};
      end else begin
        idx_nxt_s = idx_r + IW'(1);
      end
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Current digit selection from the shadow, plus the leading-zero test (digits at/above idx all zero).
  always_comb begin
    dig_on_s  = DIG_ONE << idx_r;
    hi_mask_s = {NUM_DIGITS{1'b1}} << idx_r;
    cur_nib_s = 4'h0;
    hi_nz_s   = 1'b0;
    cur_dp_s  = |(shadow_dp_r & dig_on_s);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      cur_nib_s = cur_nib_s | (shadow_data_r[4*k +: 4] & {4{dig_on_s[k]}});
      hi_nz_s   = hi_nz_s | ((|shadow_data_r[4*k +: 4]) & hi_mask_s[k]);
    end
    cur_blank_s = LZ_EN & (idx_r != {IW{1'b0}}) & ~hi_nz_s;
  end

  // Scan state: counter, index, FSM state, and the per-slot latch that prevents tearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r        <= {CW{1'b0}};
      idx_r        <= {IW{1'b0}};
      state_r      <= ST_BLANK;
      slot_nib_r   <= 4'h0;
      slot_dp_r    <= 1'b0;
      slot_blank_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      state_r <= state_nxt_s;
      if (cnt_r == {CW{1'b0}}) begin
        slot_nib_r   <= cur_nib_s;
        slot_dp_r    <= cur_dp_s;
        slot_blank_r <= cur_blank_s;
      end
    end
  end

  // FSM next state and next output values.
  always_comb begin
    state_nxt_s = state_r;
    seg_nxt_s   = 8'hFF;
    dig_nxt_s   = DIG_OFF;
    seg_bits_s  = slot_blank_r ? 7'h7F : seg_decode(slot_nib_r);
    case (state_r)
      ST_BLANK: begin
        if (cnt_nxt_s >= BLANK_END) begin
          state_nxt_s = ST_SHOW;
        end else begin
          state_nxt_s = ST_BLANK;
        end
      end
      ST_SHOW: begin
        seg_nxt_s = {seg_bits_s, ~slot_dp_r};
        dig_nxt_s = DIG_OFF ^ dig_on_s;
        if (cnt_nxt_s < BLANK_END) begin
          state_nxt_s = ST_BLANK;
        end else begin
          state_nxt_s = ST_SHOW;
        end
      end
      default: begin
        state_nxt_s = ST_BLANK;
      end
    endcase
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oSEG <= 8'hFF;
      oDIG <= DIG_OFF;
    end else begin
      oSEG <= seg_nxt_s;
      oDIG <= dig_nxt_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based display model queues the expected pins per cycle.
module tb_seg7_scan_driver;
  localparam int N  = 4;
  localparam int SD = 8;
  localparam int BL = 2;
  localparam int SCAN = N * SD;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [15:0] iDATA = 16'h0;
  logic [3:0]  iDP   = 4'h0;
  logic        iLOAD = 1'b0;
  logic [7:0]  oSEG;
  logic [3:0]  oDIG;

  int checks   = 0;
  int failures = 0;
  logic [11:0] sb_q[$];
  logic [11:0] mon_exp;

  logic [6:0] dec_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model state: edges since reset release, shadow contents, and the digit latched at slot start.
  int          e_cnt = 0;
  logic [15:0] m_data = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  s_nib = 4'h0;
  logic        s_dp = 1'b0;
  logic        s_blank = 1'b0;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BL), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .iDATA(iDATA), .iDP(iDP), .iLOAD(iLOAD), .oSEG(oSEG), .oDIG(oDIG)
  );

  always #5 clk = ~clk;

  // Monitor: one expected entry per output sample (each negedge, plus the instant reset asserts).
  initial begin
    forever begin
      @(negedge clk or negedge rst);
      #1;
      if (sb_q.size() > 0) begin
        mon_exp = sb_q.pop_front();
        checks++;
        if ({oSEG, oDIG} !== mon_exp) begin
          failures++;
          $display("FAIL scan t=%0t seg=%h dig=%b expected seg=%h dig=%b",
                   $time, oSEG, oDIG, mon_exp[11:4], mon_exp[3:0]);
        end
      end
    end
  end

  // One clock of stimulus; the expected pins after this edge follow from the cycle position in the scan.
  task automatic cyc(input logic ld, input logic [15:0] d, input logic [3:0] dp);
    int p, dg, off;
    logic [3:0]  one;
    logic [6:0]  segb;
    logic [15:0] hi;
    p   = e_cnt;
    dg  = (p / SD) % N;
    off = p % SD;
    iLOAD = ld;
    iDATA = d;
    iDP   = dp;
    if (off == 0) begin
      s_nib   = m_data[dg*4 +: 4];
      s_dp    = m_dp[dg];
      hi      = m_data >> (dg * 4);
      s_blank = LZ && (dg != 0) && (hi == 16'h0);
    end
    @(posedge clk);
    if (ld) begin
      m_data = d;
      m_dp   = dp;
    end
    if (off < BL) begin
      sb_q.push_back({8'hFF, 4'hF});
    end else begin
      one  = 4'b0001 << dg;
      segb = s_blank ? 7'h7F : dec_tab[s_nib];
      sb_q.push_back({segb, ~s_dp, ~one});
    end
    e_cnt++;
    #1;
    iLOAD = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'($urandom), 4'($urandom));
  endtask

  // Advance until the next edge lands on the given position within the scan period.
  task automatic run_to(input int target);
    for (int i = 0; i < SCAN && (e_cnt % SCAN) != target; i++) cyc(1'b0, 16'($urandom), 4'($urandom));
    checks++;
    if ((e_cnt % SCAN) != target) begin
      failures++;
      $display("FAIL run_to t=%0t expired at position %0d waiting for %0d", $time, e_cnt % SCAN, target);
    end
  endtask

  // Direct reset-state comparison of the pins.
  task automatic chk_dark(input string tag);
    checks++;
    if ((oSEG !== 8'hFF) || (oDIG !== 4'hF)) begin
      failures++;
      $display("FAIL reset %s t=%0t seg=%h dig=%b expected seg=ff dig=1111", tag, $time, oSEG, oDIG);
    end
  endtask

  // Asynchronous reset: the pins must go dark at once, and stay dark while held.
  task automatic do_reset(input int hold);
    sb_q.push_back({8'hFF, 4'hF});
    rst    = 1'b0;
    iLOAD  = 1'b0;
    m_data = 16'h0;
    m_dp   = 4'h0;
    e_cnt  = 0;
    #1;
    chk_dark("assert");
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      sb_q.push_back({8'hFF, 4'hF});
      chk_dark("hold");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2;
    do_reset(3);
    idle(34);
    cyc(1'b1, 16'h1234, 4'h0);
    idle(40);
    cyc(1'b1, 16'hABCD, 4'b0100);
    idle(36);
    cyc(1'b1, 16'h5555, 4'h0);
    run_to(SD + 4);
    cyc(1'b1, 16'h6666, 4'h0);
    idle(30);
    run_to(2 * SD + 5);
    @(negedge clk);
    #2;
    do_reset(2);
    idle(40);
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom));
    end
    cyc(1'b1, 16'h0070, 4'h0);
    idle(34);
    cyc(1'b1, 16'h0000, 4'h0);
    idle(34);
    cyc(1'b1, 16'h0900, 4'b0010);
    idle(34);
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
